mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle control with a Moore FSM that walks each instruction through fetch, decode, execute, memory and writeback. It drives all datapath mux selects and write enables, and it handshakes with a shared instruction/data memory port. It also counts retired instructions and traps on illegal opcodes or a memory timeout.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before entering TRAP
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  leave IDLE and begin fetching when 1
opcode  in  6  instruction[31:26] from IR
funct  in  6  instruction[5:0] from IR
mem_ready  in  1  memory completed current request this cycle
mem_req  out  1  memory access request
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  read strobe
mem_write  out  1  write strobe
ir_write  out  1  load IR
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A
state  out  4  current state, debug
trap  out  1  sticky, high in TRAP
retired  out  CNT_W  instructions completed since reset

Behaviour:
- rst low (async): state=IDLE, retired=0, timeout counter=0, all outputs 0.
- Outputs are a pure Moore decode of the registered state. Signals not listed for a state are 0.
- IDLE(0): all 0. Goes to FETCH when run=1.
- FETCH(1): mem_req, mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1. This is the sole Mealy qualification.
  - Holds until mem_ready, then goes to DECODE.
- DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precomputed). Next state by opcode:
  - 000000 -> EXEC_R, except funct=001000 (jr) -> JR
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL
  - 001000 -> ADDI_EX
  - anything else -> TRAP
- MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD(4): mem_req, mem_read, iord=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB(5): reg_write, reg_dst=00, mem_to_reg=01. Retires, then goes to FETCH.
- MEM_WR(6): mem_req, mem_write, iord=1. Holds until mem_ready, then retires and goes to FETCH.
- EXEC_R(7): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB(8): reg_write, reg_dst=01, mem_to_reg=00. Retires, then goes to FETCH.
- BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. Retires, then goes to FETCH.
- JUMP(10): pc_write, pc_source=10. Retires, then goes to FETCH.
- JAL(11): pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10. Retires, then goes to FETCH.
  - The datapath writes the old PC+4, which is already held in PC.
- JR(12): pc_write, pc_source=11. Retires, then goes to FETCH.
- ADDI_EX(13): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB(14): reg_write, reg_dst=00, mem_to_reg=00. Retires, then goes to FETCH.
- TRAP(15): trap=1, all other outputs 0. Exits only on rst.
- Retire: retired increments by 1 on the exit edge of the retiring state. It wraps modulo 2^CNT_W silently.
- Timeout:
  - The counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments each waiting cycle with mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0, go to TRAP.
  - mem_ready=1 on the same cycle the count hits TIMEOUT wins (normal advance).
- mem_ready is ignored in states without mem_req.
- run is sampled only in IDLE. Deasserting run mid-instruction has no effect.
- Reset mid-instruction aborts immediately. No partial writes are emitted after rst falls.
- Latencies with zero-wait memory: R, addi = 4 cycles; lw = 5; sw = 4; beq, j, jal, jr = 3.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state encoding constants (IDLE..TRAP, 4 bits)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, plus FUNCT_JR
  - the alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg encodings
- One sub-module, mips_ctrl_decode: combinational state-to-control-vector table. The FSM, timeout counter and retire counter stay in the top.

Test Plan:
- Reset then run=1, opcode=000000, funct=100000, mem_ready=1 always -> states 1,2,7,8,1. reg_write=1, reg_dst=01 in state 8. retired=1 after 4 cycles.
- lw (100011) with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> ir_write pulses exactly once. State 4 held 4 cycles. reg_write with mem_to_reg=01 once. Total 11 cycles.
- jal (000011) -> state 11 asserts pc_write, pc_source=10, reg_dst=10, mem_to_reg=10, reg_write together. retired increments.
- opcode=111111 -> DECODE then TRAP. trap=1 and held for 20 cycles; all write enables stay 0.
- mem_ready held 0 in FETCH with TIMEOUT=16 -> TRAP entered after exactly 16 waiting cycles. A variant with mem_ready=1 on cycle 16 advances to DECODE instead.
- rst dropped mid-MEM_WR with mem_write high -> mem_write, state and retired go to 0 asynchronously before the next clk edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS sequencer
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12,
    S_ADDI_EX  = 4'd13,
    S_ADDI_WB  = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctrl_t;

  // States that complete an instruction unconditionally on their single cycle.
  function automatic logic retires_now(input state_t s);
    case (s)
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ADDI_WB: retires_now = 1'b1;
      default: retires_now = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - state to datapath control vector table
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC load only on the cycle the fetch actually completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        // PC already holds PC+4, which is the link value written to $31
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RA;
        ctrl.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_REGA;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_TRAP: ctrl.trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory timeout and retire counter
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        cur;
  logic [TW-1:0] tcnt;
  ctrl_t         ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= S_IDLE;
      tcnt    <= '0;
      retired <= '0;
    end else begin
      case (cur)
        S_IDLE: if (run) cur <= S_FETCH;
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          // Counter is zeroed on every advance, so each wait state starts from 0
          if (mem_ready) begin
            tcnt <= '0;
            case (cur)
              S_FETCH:  cur <= S_DECODE;
              S_MEM_RD: cur <= S_MEM_WB;
              default: begin
                cur     <= S_FETCH;
                retired <= retired + 1'b1;
              end
            endcase
          end else if (tcnt == TLAST) begin
            cur <= S_TRAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     cur <= (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW: cur <= S_MEM_ADDR;
            OP_BEQ:       cur <= S_BRANCH;
            OP_J:         cur <= S_JUMP;
            OP_JAL:       cur <= S_JAL;
            OP_ADDI:      cur <= S_ADDI_EX;
            default:      cur <= S_TRAP;
          endcase
        end
        S_MEM_ADDR: cur <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_EXEC_R:   cur <= S_R_WB;
        S_ADDI_EX:  cur <= S_ADDI_WB;
        S_TRAP:     cur <= S_TRAP;
        default: begin
          if (retires_now(cur)) begin
            cur     <= S_FETCH;
            retired <= retired + 1'b1;
          end
        end
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state     (cur),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign state         = cur;
  assign mem_req       = ctrl.mem_req;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign trap          = ctrl.trap;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, mem_ready;
  logic [5:0]  opcode, funct;
  logic        mem_req, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic        reg_write, alu_src_a, trap;
  logic [3:0]  state;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  int lw_state [11] = '{1, 1, 1, 1, 2, 3, 4, 4, 4, 4, 5};
  int lw_rdy   [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};

  logic [5:0] pc_ops   [3] = '{6'b000100, 6'b000010, 6'b000000};
  logic [5:0] pc_funct [3] = '{6'b000000, 6'b000000, 6'b001000};
  int         pc_state [3] = '{9, 10, 12};
  int         pc_src   [3] = '{1, 2, 3};
  int         pc_wr    [3] = '{0, 1, 1};

  mips_multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .opcode        (opcode),
    .funct         (funct),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .trap          (trap),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int irw, wbs, rds;
    logic [6:0] we;

    // reset state
    rst = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = '0; funct = '0;
    #2;
    check("rst_state", state, 0);
    check("rst_retired", retired, 0);
    check("rst_outs", {mem_req, pc_write, ir_write, reg_write, mem_write, trap}, 0);

    // R-type add with zero-wait memory
    reset_dut();
    opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1; run = 1'b1;
    cyc();
    run = 1'b0;
    check("r_fetch", state, 1);
    check("r_fetch_ld", {mem_req, mem_read, iord, ir_write, pc_write, alu_src_b}, 32'b1_1_0_1_1_01);
    cyc();
    check("r_decode", {state, alu_src_b}, {4'd2, 2'b11});
    cyc();
    check("r_exec", {state, alu_src_a, alu_src_b, alu_op}, {4'd7, 1'b1, 2'b00, 2'b10});
    cyc();
    check("r_wb", {state, reg_write, reg_dst, mem_to_reg}, {4'd8, 1'b1, 2'b01, 2'b00});
    cyc();
    check("r_back", state, 1);
    check("r_retired", retired, 1);

    // lw with 3 wait cycles in FETCH and MEM_RD
    reset_dut();
    opcode = 6'b100011; run = 1'b1;
    cyc();
    run = 1'b0;
    irw = 0; wbs = 0; rds = 0;
    for (int i = 0; i < 11; i++) begin
      mem_ready = lw_rdy[i][0];
      #1;
      check($sformatf("lw_state%0d", i), state, lw_state[i]);
      irw += int'(ir_write);
      if (reg_write && mem_to_reg == 2'b01) wbs++;
      if (state == 4'd4) rds++;
      cyc();
    end
    check("lw_irw", irw, 1);
    check("lw_wb", wbs, 1);
    check("lw_rd_cycles", rds, 4);
    check("lw_end", state, 1);
    check("lw_retired", retired, 1);

    // jal
    reset_dut();
    opcode = 6'b000011; mem_ready = 1'b1; run = 1'b1;
    cyc(); cyc(); cyc();
    check("jal_ctrl", {state, pc_write, pc_source, reg_dst, mem_to_reg, reg_write},
          {4'd11, 1'b1, 2'b10, 2'b10, 2'b10, 1'b1});
    cyc();
    check("jal_retired", {state, retired[3:0]}, {4'd1, 4'd1});

    // beq, j, jr: three cycles each
    for (int k = 0; k < 3; k++) begin
      reset_dut();
      opcode = pc_ops[k]; funct = pc_funct[k]; mem_ready = 1'b1; run = 1'b1;
      cyc(); cyc(); cyc();
      check($sformatf("pc_state%0d", k), state, pc_state[k]);
      check($sformatf("pc_ctrl%0d", k), {pc_source, pc_write, pc_write_cond},
            {pc_src[k][1:0], pc_wr[k][0], ~pc_wr[k][0]});
      cyc();
      check($sformatf("pc_ret%0d", k), {state, retired[3:0]}, {4'd1, 4'd1});
    end

    // illegal opcode traps and stays
    reset_dut();
    opcode = 6'b111111; mem_ready = 1'b1; run = 1'b1;
    cyc(); cyc();
    check("ill_decode", state, 2);
    cyc();
    for (int i = 0; i < 20; i++) begin
      we = {pc_write, pc_write_cond, mem_write, mem_read, ir_write, reg_write, mem_req};
      check($sformatf("ill_trap%0d", i), {state, trap, we}, {4'd15, 1'b1, 7'd0});
      cyc();
    end
    check("ill_retired", retired, 0);

    // FETCH timeout: 16 waiting cycles then TRAP
    reset_dut();
    run = 1'b1; mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_wait%0d", i), state, 1);
      cyc();
    end
    check("to_trap", {state, trap}, {4'd15, 1'b1});

    // mem_ready on the 16th waiting cycle wins
    reset_dut();
    run = 1'b1; mem_ready = 1'b0; opcode = 6'b001000;
    cyc();
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i == 15);
      cyc();
    end
    check("to_edge", {state, trap}, {4'd2, 1'b0});

    // sw retires, then reset dropped while the next sw is writing
    reset_dut();
    opcode = 6'b101011; mem_ready = 1'b1; run = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check("sw_wr", {state, mem_write, iord, mem_req}, {4'd6, 1'b1, 1'b1, 1'b1});
    cyc();
    check("sw_ret", {state, retired[3:0]}, {4'd1, 4'd1});
    cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    #1;
    check("sw_hold", {state, mem_write}, {4'd6, 1'b1});
    rst = 1'b0;
    #1;
    check("async_rst", {state, mem_write}, {4'd0, 1'b0});
    check("async_ret", retired, 0);
    rst = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
